// File: rtl/jtdsp16_fetch_seq.sv
// Instruction fetch sequencer for the XAAU: decodes ROM words, squashes words fetched
// behind a PC redirect, sequences the second word of R=N and arbitrates the external irq.
module jtdsp16_fetch_seq #(
  parameter int ROM_LAT = 1,
  parameter bit IRQ_EN  = 1'b1
) (
  input  logic        rst_i,
  input  logic        clk_i,
  input  logic        cen_i,
  input  logic [15:0] rom_dout_i,
  input  logic        irq_i,
  input  logic        halt_i,
  output logic        goto_ja_o,
  output logic        call_ja_o,
  output logic        goto_b_o,
  output logic        icall_o,
  output logic        ram_load_o,
  output logic        post_inc_o,
  output logic        imm_load_o,
  output logic        pc_halt_o,
  output logic [2:0]  r_field_o,
  output logic [11:0] i_field_o,
  output logic        ext_irq_o,
  output logic        shadow_o,
  output logic [15:0] inst_o,
  output logic        inst_ok_o
);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_IMM   = 2'd2
  } state_t;

  localparam logic [1:0] SQ_INIT = 2'(ROM_LAT);

  state_t      state_q, state_d;
  logic [1:0]  sq_q, sq_d;
  logic        shadow_q, shadow_d;
  logic [2:0]  rlat_q, rlat_d;

  logic [4:0]  t_s;
  logic        exec_s;
  logic        is_gja_s, is_cja_s, is_gb_s, is_ic_s, is_rl_s, is_rn_s;
  logic        redirect_word_s;
  logic        ireturn_s;

  // Instruction class decode, qualified by a live executing slot
  always_comb begin
    t_s             = rom_dout_i[15:11];
    exec_s          = (state_q == ST_EXEC) && !halt_i;
    is_gja_s        = (t_s[4:1] == 4'b0000);
    is_cja_s        = (t_s[4:1] == 4'b1000);
    is_gb_s         = (t_s == 5'b11000);
    is_ic_s         = (t_s == 5'b01110);
    is_rl_s         = (t_s == 5'b00111);
    is_rn_s         = (t_s == 5'b01010);
    redirect_word_s = is_gja_s | is_cja_s | is_gb_s | is_ic_s;
    ireturn_s       = is_gb_s && (rom_dout_i[10:8] == 3'b001);
  end

  // Output strobes and fields; the irq never steals a slot that already redirects or owns an immediate
  always_comb begin
    goto_ja_o  = exec_s & is_gja_s;
    call_ja_o  = exec_s & is_cja_s;
    goto_b_o   = exec_s & is_gb_s;
    icall_o    = exec_s & is_ic_s;
    ram_load_o = exec_s & is_rl_s;
    post_inc_o = exec_s & is_rl_s & rom_dout_i[0];
    imm_load_o = (state_q == ST_IMM) && !halt_i;
    pc_halt_o  = halt_i;
    ext_irq_o  = IRQ_EN & irq_i & ~shadow_q & exec_s & ~redirect_word_s & ~is_rn_s;
    shadow_o   = shadow_q;
    inst_o     = rom_dout_i;
    i_field_o  = rom_dout_i[11:0];
    inst_ok_o  = exec_s;
    if (state_q == ST_IMM) begin
      r_field_o = rlat_q;
    end else begin
      r_field_o = rom_dout_i[6:4];
    end
  end

  // Next-state: squash countdown, immediate sequencing and interrupt shadow
  always_comb begin
    state_d  = state_q;
    sq_d     = sq_q;
    shadow_d = shadow_q;
    rlat_d   = rlat_q;
    if (!halt_i) begin
      case (state_q)
        ST_FLUSH: begin
          sq_d = sq_q - 2'd1;
          if (sq_q <= 2'd1) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        ST_EXEC: begin
          if (goto_ja_o | call_ja_o | icall_o | goto_b_o | ext_irq_o) begin
            state_d = ST_FLUSH;
            sq_d    = SQ_INIT;
          end else if (is_rn_s) begin
            state_d = ST_IMM;
            rlat_d  = rom_dout_i[6:4];
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_IMM: begin
          state_d = ST_EXEC;
        end
        default: begin
          state_d = ST_FLUSH;
          sq_d    = SQ_INIT;
        end
      endcase
      if (ext_irq_o | icall_o) begin
        shadow_d = 1'b1;
      end else if (goto_b_o & ireturn_s) begin
        shadow_d = 1'b0;
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      state_d  = state_q;
      sq_d     = sq_q;
      shadow_d = shadow_q;
      rlat_d   = rlat_q;
    end
  end

  // State registers, advanced only on enabled cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_FLUSH;
      sq_q     <= SQ_INIT;
      shadow_q <= 1'b0;
      rlat_q   <= 3'd0;
    end else if (cen_i) begin
      state_q  <= state_d;
      sq_q     <= sq_d;
      shadow_q <= shadow_d;
      rlat_q   <= rlat_d;
    end
  end

endmodule
